// File: rtl/shift_rows.sv
// AES ShiftRows byte permutation (InvShiftRows when INVERSE=1) feeding a single output register.
// Latency 1 cycle, one state accepted every cycle; no backpressure, data_in is taken unconditionally.
module shift_rows #(
  parameter bit INVERSE = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] data_in,
  output logic [127:0] data_out
);

  logic [127:0] perm_dat;

  // Byte i = r + 4c sits at [127-8i -: 8]; row r rotates left by r columns (right when inverting).
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int SRC_C = INVERSE ? ((c - r + 4) % 4) : ((c + r) % 4);
      assign perm_dat[127 - 8*(r + 4*c) -: 8] = data_in[127 - 8*(r + 4*SRC_C) -: 8];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out <= '0;
    end else begin
      data_out <= perm_dat;
    end
  end

endmodule

// File: tb/tb_shift_rows.sv
// Directed bench for shift_rows: a forward and an inverse instance, optionally chained for round trip.
module tb_shift_rows;

  logic         clk;
  logic         rst;
  logic [127:0] fwd_in;
  logic [127:0] fwd_out;
  logic [127:0] inv_drv;
  logic [127:0] inv_in;
  logic [127:0] inv_out;
  logic         chain;

  int n_checks;
  int n_fail;

  assign inv_in = chain ? fwd_out : inv_drv;

  shift_rows #(.INVERSE(1'b0)) u_fwd (
    .clk      (clk),
    .rst      (rst),
    .data_in  (fwd_in),
    .data_out (fwd_out)
  );

  shift_rows #(.INVERSE(1'b1)) u_inv (
    .clk      (clk),
    .rst      (rst),
    .data_in  (inv_in),
    .data_out (inv_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source byte tables written out from the published permutation lists.
  function automatic logic [127:0] model_fwd(input logic [127:0] x);
    int src [16] = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};
    logic [127:0] y;
    y = '0;
    for (int i = 0; i < 16; i++) y[127 - 8*i -: 8] = x[127 - 8*src[i] -: 8];
    return y;
  endfunction

  function automatic logic [127:0] model_inv(input logic [127:0] x);
    int src [16] = '{0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3};
    logic [127:0] y;
    y = '0;
    for (int i = 0; i < 16; i++) y[127 - 8*i -: 8] = x[127 - 8*src[i] -: 8];
    return y;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (fwd_out !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_pre_edge: got %h want %h", fwd_out, 128'h0);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if (fwd_out !== 128'h0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got %h want %h", k, fwd_out, 128'h0);
      end
    end
  endtask

  task automatic test_sparse();
    fwd_in = 128'h00000000_00000000_00000000_ffffffff;
    rst    = 1'b1;
    tick();
    n_checks++;
    if (fwd_out !== 128'h000000ff_0000ff00_00ff0000_ff000000) begin
      n_fail++;
      $display("FAIL sparse: got %h want %h", fwd_out, 128'h000000ff_0000ff00_00ff0000_ff000000);
    end
  endtask

  task automatic test_fips();
    fwd_in = 128'hd42711aee0bf98f1b8b45de51e415230;
    tick();
    n_checks++;
    if (fwd_out !== 128'hd4bf5d30e0b452aeb84111f11e2798e5) begin
      n_fail++;
      $display("FAIL fips_round1: got %h want %h", fwd_out, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
    end
  endtask

  task automatic test_index();
    fwd_in  = 128'h000102030405060708090a0b0c0d0e0f;
    inv_drv = 128'h000102030405060708090a0b0c0d0e0f;
    tick();
    n_checks++;
    if (fwd_out !== 128'h00050a0f04090e03080d02070c01060b) begin
      n_fail++;
      $display("FAIL index_fwd: got %h want %h", fwd_out, 128'h00050a0f04090e03080d02070c01060b);
    end
    n_checks++;
    if (inv_out !== 128'h000d0a0704010e0b0805020f0c090603) begin
      n_fail++;
      $display("FAIL index_inv: got %h want %h", inv_out, 128'h000d0a0704010e0b0805020f0c090603);
    end
  endtask

  task automatic test_round_trip();
    chain  = 1'b1;
    fwd_in = 128'hd42711aee0bf98f1b8b45de51e415230;
    tick();
    fwd_in = 128'h0;
    tick();
    n_checks++;
    if (inv_out !== 128'hd42711aee0bf98f1b8b45de51e415230) begin
      n_fail++;
      $display("FAIL round_trip: got %h want %h", inv_out, 128'hd42711aee0bf98f1b8b45de51e415230);
    end
    chain = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [127:0] base;
    logic [127:0] v;
    base = 128'h0123456789abcdeffedcba9876543210;
    for (int i = 0; i < 8; i++) begin
      v       = (base << (8*i)) | (base >> (128 - 8*i)) ^ {16{8'(i * 37)}};
      fwd_in  = v;
      inv_drv = ~v;
      tick();
      n_checks++;
      if (fwd_out !== model_fwd(v)) begin
        n_fail++;
        $display("FAIL stream_fwd[%0d]: got %h want %h", i, fwd_out, model_fwd(v));
      end
      n_checks++;
      if (inv_out !== model_inv(~v)) begin
        n_fail++;
        $display("FAIL stream_inv[%0d]: got %h want %h", i, inv_out, model_inv(~v));
      end
    end
  endtask

  task automatic test_async_reset();
    fwd_in = 128'hcafef00d_deadbeef_01234567_89abcdef;
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (fwd_out !== 128'h0) begin
      n_fail++;
      $display("FAIL async_clear: got %h want %h", fwd_out, 128'h0);
    end
    tick();
    n_checks++;
    if (fwd_out !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_ignores_edge: got %h want %h", fwd_out, 128'h0);
    end
    fwd_in = 128'h000102030405060708090a0b0c0d0e0f;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (fwd_out !== 128'h0) begin
      n_fail++;
      $display("FAIL release_no_edge: got %h want %h", fwd_out, 128'h0);
    end
    tick();
    n_checks++;
    if (fwd_out !== 128'h00050a0f04090e03080d02070c01060b) begin
      n_fail++;
      $display("FAIL release_load: got %h want %h", fwd_out, 128'h00050a0f04090e03080d02070c01060b);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    chain    = 1'b0;
    rst      = 1'b0;
    fwd_in   = 128'hffffffff;
    inv_drv  = 128'hffffffff;
    test_reset();
    test_sparse();
    test_fips();
    test_index();
    test_round_trip();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
